// File: rtl/pll_lock_sequencer_if.sv
// PLL supervision bundle: PLL lock input plus reset, status and debug outputs.
// The sequencer attaches through the slave modport; the environment uses master.
interface pll_lock_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             pll_locked;
    logic             pll_rst;
    logic             sys_rst;
    logic             ready;
    logic [2:0]       state;
    logic             timeout_err;
    logic [CNT_W-1:0] loss_count;

    modport master (
        output pll_locked,
        input  pll_rst, sys_rst, ready, state, timeout_err, loss_count
    );

    modport slave (
        input  pll_locked,
        output pll_rst, sys_rst, ready, state, timeout_err, loss_count
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor on refclk: pulses the PLL reset, qualifies lock, gates sys_rst.
// Optional macro PLL_LOSS_COUNT_EN builds the saturating lock-loss counter (tied to 0 otherwise).
module pll_lock_sequencer #(
    parameter int unsigned RST_PULSE_CYC    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned STABLE_CYC       = 1024,
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned CNT_W            = 8
) (
    input  logic                 i_refclk,
    input  logic                 i_rst,
    pll_lock_sequencer_if.slave  io_bus
);

    localparam int unsigned MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > STABLE_CYC) ? MAX_AB : STABLE_CYC;
    localparam int unsigned CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CYC_W-1:0] RST_LAST    = CYC_W'(RST_PULSE_CYC - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CYC_W-1:0] STABLE_LAST = CYC_W'(STABLE_CYC - 1);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_LOST      = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lk_s;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_timeout;
    logic [CYC_W-1:0]       r_cnt;
    logic                   r_pll_rst;
    logic                   r_sys_rst;
    logic                   r_ready;
    logic                   r_timeout_err;

    // Lock flag is asynchronous to refclk
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], io_bus.pll_locked};
        end
    end

    assign w_lk_s = r_sync[SYNC_STAGES-1];

    // Next-state decision; lock wins over a coincident timeout
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_PLL_RST: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (w_lk_s) begin
                    w_state_nxt = S_STABLE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_PLL_RST;
                end
            end
            S_STABLE: begin
                if (!w_lk_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_lk_s) begin
                    w_state_nxt = S_LOST;
                end
            end
            S_LOST:  w_state_nxt = S_PLL_RST;
            default: w_state_nxt = S_PLL_RST;
        endcase
    end

    // State, dwell counter and outputs registered together so outputs track the state register
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state       <= S_PLL_RST;
            r_cnt         <= '0;
            r_pll_rst     <= 1'b1;
            r_sys_rst     <= 1'b1;
            r_ready       <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state inside {S_PLL_RST, S_WAIT_LOCK, S_STABLE}) begin
                r_cnt <= r_cnt + CYC_W'(1);
            end
            r_pll_rst <= (w_state_nxt == S_PLL_RST);
            r_sys_rst <= (w_state_nxt != S_RUN);
            r_ready   <= (w_state_nxt == S_RUN);
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

`ifdef PLL_LOSS_COUNT_EN
    localparam logic [CNT_W-1:0] LOSS_MAX = '1;

    logic [CNT_W-1:0] r_loss_count;

    // Counts RUN -> LOST transitions, saturating
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_loss_count <= '0;
        end else if ((r_state == S_RUN) && !w_lk_s && (r_loss_count != LOSS_MAX)) begin
            r_loss_count <= r_loss_count + CNT_W'(1);
        end
    end

    assign io_bus.loss_count = r_loss_count;
`else
    assign io_bus.loss_count = CNT_W'(0);
`endif

    assign io_bus.pll_rst     = r_pll_rst;
    assign io_bus.sys_rst     = r_sys_rst;
    assign io_bus.ready       = r_ready;
    assign io_bus.state       = r_state;
    assign io_bus.timeout_err = r_timeout_err;

endmodule
